// File: rtl/dsa_sched_pkg.sv
// Shared types for the DSA job scheduler: FSM state encoding, error codes
// and the Q8.8 output-size helper.
package dsa_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4
  } sched_state_e;

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_CFG  = 2'd1,
    ERR_SIZE = 2'd2,
    ERR_TMO  = 2'd3
  } err_e;

  // Output dimension for a Q8.8 scale: 32-bit product, >>8, truncated to 16 bits.
  function automatic logic [15:0] scale_dim(input logic [15:0] dim, input logic [15:0] scale);
    logic [31:0] prod;
    prod = 32'(dim) * 32'(scale);
    return prod[23:8];
  endfunction

endpackage

// File: rtl/sched_wr_fifo.sv
// Small synchronous FIFO buffering {addr, data} BRAM writes while a job runs.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module sched_wr_fifo #(
  parameter int DW    = 20,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_last
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_last    = (r_count == CNT_ONE);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dsa_job_sched.sv
// Job controller for the bilinear core: start arbitration, config snapshot and
// validation, launch pulse, watchdog, status word and buffered BRAM write port.
module dsa_job_sched
  import dsa_sched_pkg::*;
#(
  parameter int AW         = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_W  = 24
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          start_jtag,
  input  logic          start_sw,
  input  logic [15:0]   cfg_in_w,
  input  logic [15:0]   cfg_in_h,
  input  logic [15:0]   cfg_scale_q88,
  output logic          core_start,
  output logic [15:0]   core_in_w,
  output logic [15:0]   core_in_h,
  output logic [15:0]   core_scale_q88,
  input  logic          core_done,
  input  logic [AW-1:0] jw_addr,
  input  logic [7:0]    jw_data,
  input  logic          jw_we,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic          st_busy,
  output logic          st_done,
  output logic [1:0]    st_err,
  output logic          st_drop,
  output logic [31:0]   st_cycles
);
  localparam int          FW        = AW + 8;
  localparam logic [31:0] MEM_BYTES = 32'd1 << AW;
  localparam logic [TIMEOUT_W-1:0] WDOG_ONE = 1;

  sched_state_e         r_state;
  logic [15:0]          r_in_w;
  logic [15:0]          r_in_h;
  logic [15:0]          r_scale;
  logic                 r_core_start;
  logic                 r_done;
  logic                 r_drop;
  err_e                 r_err;
  logic [31:0]          r_cycles;
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                 r_fwd_we;
  logic [AW-1:0]        r_fwd_addr;
  logic [7:0]           r_fwd_data;

  logic                 w_start;
  logic                 w_buffering;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_last;
  logic [FW-1:0]        w_fifo_dout;
  logic [15:0]          w_out_w;
  logic [15:0]          w_out_h;
  logic                 w_cfg_bad;
  logic                 w_size_bad;
  logic [TIMEOUT_W-1:0] w_wdog_inc;
  logic                 w_drain_done;

  assign w_start     = start_jtag | start_sw;
  assign w_buffering = (r_state == LAUNCH) || (r_state == RUN) || (r_state == DRAIN);
  assign w_push      = jw_we && w_buffering;
  assign w_pop       = (r_state == DRAIN) && !w_empty;
  assign w_out_w     = scale_dim(r_in_w, r_scale);
  assign w_out_h     = scale_dim(r_in_h, r_scale);
  assign w_cfg_bad   = (r_in_w < 16'd2) || (r_in_h < 16'd2) || (r_scale == 16'd0) ||
                       (w_out_w == 16'd0) || (w_out_h == 16'd0);
  assign w_size_bad  = ((32'(r_in_w) * 32'(r_in_h)) > MEM_BYTES) ||
                       ((32'(w_out_w) * 32'(w_out_h)) > MEM_BYTES);
  assign w_wdog_inc  = r_wdog + WDOG_ONE;
  // DRAIN pops every cycle, so a single remaining entry leaves the FIFO empty.
  assign w_drain_done = !w_push && (w_empty || w_last);

  sched_wr_fifo #(
    .DW    (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk_50),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ({jw_addr, jw_data}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_last  (w_last)
  );

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_in_w       <= '0;
      r_in_h       <= '0;
      r_scale      <= '0;
      r_core_start <= 1'b0;
      r_done       <= 1'b0;
      r_drop       <= 1'b0;
      r_err        <= ERR_OK;
      r_cycles     <= '0;
      r_wdog       <= '0;
      r_fwd_we     <= 1'b0;
      r_fwd_addr   <= '0;
      r_fwd_data   <= '0;
    end else begin
      r_core_start <= 1'b0;
      r_fwd_we     <= 1'b0;
      if ((r_state == IDLE) || (r_state == CHECK)) begin
        r_fwd_we   <= jw_we;
        r_fwd_addr <= jw_addr;
        r_fwd_data <= jw_data;
      end
      if (w_push && w_full && !w_pop) r_drop <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_in_w   <= cfg_in_w;
            r_in_h   <= cfg_in_h;
            r_scale  <= cfg_scale_q88;
            r_done   <= 1'b0;
            r_err    <= ERR_OK;
            r_drop   <= 1'b0;
            r_cycles <= '0;
            r_state  <= CHECK;
          end
        end
        CHECK: begin
          if (w_cfg_bad) begin
            r_err   <= ERR_CFG;
            r_state <= IDLE;
          end else if (w_size_bad) begin
            r_err   <= ERR_SIZE;
            r_state <= IDLE;
          end else begin
            r_core_start <= 1'b1;
            r_state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_wdog  <= '0;
          r_state <= RUN;
        end
        RUN: begin
          if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
          // Timeout is only reported; the job keeps waiting for core_done.
          if (!(&r_wdog)) begin
            r_wdog <= w_wdog_inc;
            if (&w_wdog_inc) r_err <= ERR_TMO;
          end
          if (core_done) begin
            r_done  <= 1'b1;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_drain_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_start     = r_core_start;
  assign core_in_w      = r_in_w;
  assign core_in_h      = r_in_h;
  assign core_scale_q88 = r_scale;
  assign st_busy        = (r_state != IDLE);
  assign st_done        = r_done;
  assign st_err         = r_err;
  assign st_drop        = r_drop;
  assign st_cycles      = r_cycles;
  assign mem_we         = r_fwd_we | w_pop;
  assign mem_waddr      = w_pop ? w_fifo_dout[FW-1:8] : r_fwd_addr;
  assign mem_wdata      = w_pop ? w_fifo_dout[7:0]    : r_fwd_data;

endmodule

// File: doc/dsa_job_sched.md
# dsa_job_sched

Job controller placed between the JTAG/switch control plane and the sequential bilinear core. It arbitrates start requests, snapshots and validates the configuration, and launches the core with a single start pulse. It owns the input-BRAM write port: writes arriving during a job are buffered in a small FIFO and replayed afterwards instead of being dropped. It also exports a status word (busy, done, error code, overflow, job cycle count) for JTAG readback.

## Interface

Parameters:
- AW, 12, BRAM address width; memory capacity is 2^AW bytes
- FIFO_DEPTH, 4, write-buffer entries (power of two, ≥2)
- TIMEOUT_W, 24, width of the run-watchdog counter

Ports:
- clk_50  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- start_jtag  in  1  one-cycle start request from JTAG
- start_sw  in  1  one-cycle start request from debounced switch
- cfg_in_w, cfg_in_h, cfg_scale_q88  in  16 each  live configuration; scale is Q8.8
- core_start  out  1  one-cycle launch pulse to the core
- core_in_w, core_in_h, core_scale_q88  out  16 each  configuration snapshot, stable for the whole job
- core_done  in  1  core completion pulse
- jw_addr  in  AW; jw_data  in  8; jw_we  in  1  JTAG write request to input BRAM
- mem_waddr  out  AW; mem_wdata  out  8; mem_we  out  1  arbitrated BRAM write port
- st_busy  out  1  high in any state except IDLE
- st_done  out  1  job completed
- st_err  out  2  0 ok, 1 bad config, 2 size overflow, 3 watchdog timeout
- st_drop  out  1  sticky: a write was lost because the FIFO was full
- st_cycles  out  32  RUN-cycle count of the last or current job

## Operation

- FSM states: IDLE, CHECK, LAUNCH, RUN, DRAIN.
- IDLE: start_jtag | start_sw is an accepted start (both asserted in the same cycle count as one start). On accept:
  - snapshot cfg_* into core_*
  - clear st_done, st_err, st_drop and st_cycles
  - go to CHECK
- Start requests outside IDLE are ignored.
- CHECK, one cycle, on registered values:
  - out_w = (in_w*scale)>>8, out_h = (in_h*scale)>>8, computed with 32-bit products and a 16-bit truncated result.
  - If in_w<2, in_h<2, scale==0 or out_w==0 or out_h==0: st_err=1 and go to IDLE.
  - Else if in_w*in_h > 2^AW or out_w*out_h > 2^AW: st_err=2 and go to IDLE.
  - Else go to LAUNCH.
  - st_done stays 0 on any error.
- LAUNCH: core_start=1 for exactly this cycle, then go to RUN.
- RUN:
  - st_cycles increments every cycle, saturating at all-ones.
  - The watchdog counts RUN cycles. When it reaches all-ones, st_err=3 (sticky) and the FSM keeps waiting.
  - On core_done: set st_done and go to DRAIN.
  - core_done outside RUN is ignored.
- Write arbitration:
  - IDLE/CHECK: jw_we is forwarded registered. mem_* equals jw_* one cycle later.
  - LAUNCH/RUN/DRAIN: each jw_we is pushed into the FIFO. If the push finds the FIFO full, the write is discarded and st_drop is set.
  - DRAIN: pop one entry per cycle onto mem_*. A push and a pop in the same cycle are both honoured, preserving order.
  - Leave DRAIN for IDLE when the FIFO is empty and there is no push that cycle.
- Reset mid-job: every register, the FIFO and the FSM clear immediately. Buffered writes are lost and st_drop is not set.

## Timing

- Reset values: all outputs 0; FSM in IDLE; FIFO empty.
- Start accepted at cycle t:
  - core_* are valid from t+1
  - CHECK at t+1
  - core_start high at t+2
  - RUN from t+3
- st_busy is high from t+1 through the last DRAIN cycle.
- core_done at cycle d:
  - st_done=1 from d+1
  - DRAIN from d+1
  - first buffered write on mem_* at d+1
  - N buffered entries: IDLE at d+1+N
- st_cycles counts every RUN cycle including the core_done cycle.
- Error paths: st_err is visible and st_busy=0 at t+2.

## Structure

- Package dsa_sched_pkg holds:
  - sched_state_e enum (IDLE, CHECK, LAUNCH, RUN, DRAIN)
  - err_e constants (ERR_OK=0, ERR_CFG=1, ERR_SIZE=2, ERR_TMO=3)
- Sub-module sched_wr_fifo holds the synchronous FIFO of {addr, data}: push/pop/full/empty, same-cycle push+pop on full is legal.

## Test plan

- Valid job: cfg 64×64, scale 0x0080 (0.5), start_jtag → core_start at t+2, core_* = 64/64/0x0080, core_done after 100 cycles → st_done=1, st_cycles=100, st_err=0.
- Bad config: in_w=1, or scale=0, start_sw → no core_start, st_err=1 at t+2, st_busy=0.
- Size overflow: cfg 64×64, scale 0x0200 (out 128×128=16384 > 4096) → st_err=2, no core_start.
- Buffered writes: during RUN issue writes (0x010,0xAA),(0x011,0xBB),(0x012,0xCC) → mem_we stays 0 until core_done. Then in DRAIN: 0x010/0xAA at d+1, 0x011/0xBB at d+2, 0x012/0xCC at d+3; IDLE at d+4.
- Overflow: 6 writes during RUN with FIFO_DEPTH=4 → first 4 replayed in order, st_drop=1. A new accepted start clears st_drop.
- Simultaneous and edge cases:
  - start_jtag and start_sw in the same cycle → exactly one core_start.
  - start in RUN → ignored.
  - rst_n low in RUN with 2 entries buffered → all outputs 0 and no mem_we after release.
  - TIMEOUT_W=4 with no core_done → st_err=3 after 15 RUN cycles; a later core_done still sets st_done.
